// File: rtl/spike_tally.sv
// Per-channel spike tally: decodes classifier results into cluster labels, attributes
// them round-robin to channels and keeps saturating per-channel/per-cluster counters.
module spike_tally #(
  parameter int unsigned FEATURES      = 3,
  parameter int unsigned MAX_CLUSTERS  = 5,
  parameter int unsigned CHANNEL_COUNT = 4,
  parameter int unsigned COUNT_WIDTH   = 16,
  localparam int unsigned LW   = (FEATURES > 1) ? $clog2(FEATURES) : 1,
  localparam int unsigned LBW  = (MAX_CLUSTERS > 1) ? $clog2(MAX_CLUSTERS) : 1,
  localparam int unsigned CW   = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1,
  localparam int unsigned NCNT = CHANNEL_COUNT * MAX_CLUSTERS,
  localparam int unsigned AW   = (NCNT > 1) ? $clog2(NCNT) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LW-1:0]          level,
  input  logic [LW-1:0]          path,
  input  logic                   out_valid,
  input  logic                   ch_sync,
  output logic                   label_valid,
  output logic [LBW-1:0]         label,
  output logic [CW-1:0]          label_ch,
  input  logic                   rd_req,
  input  logic [AW-1:0]          rd_addr,
  input  logic                   rd_clear,
  output logic                   rd_valid,
  output logic [COUNT_WIDTH-1:0] rd_data,
  output logic                   saturated
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  logic [COUNT_WIDTH-1:0] cnt_q [NCNT];
  logic [COUNT_WIDTH-1:0] cnt_d [NCNT];
  logic [CW-1:0]          ch_q, ch_d, ch_eff;
  logic                   label_valid_q;
  logic [LBW-1:0]         label_q;
  logic [CW-1:0]          label_ch_q;
  logic                   rd_valid_q;
  logic [COUNT_WIDTH-1:0] rd_data_q;
  logic                   saturated_q;

  logic                   sel_bit;
  logic [LW:0]            lbl_sum;
  logic [LBW-1:0]         lbl_c;
  logic [AW-1:0]          ev_idx;
  logic [COUNT_WIDTH-1:0] rd_val;
  logic                   sat_set;

  // Label decode: level plus the branch bit taken at that node; levels past the
  // last node have no branch bit and contribute zero.
  always_comb begin
    sel_bit = 1'b0;
    for (int i = 0; i < int'(LW); i++) begin
      if (level == LW'(i)) sel_bit = path[i];
    end
    lbl_sum = {1'b0, level} + (LW+1)'(sel_bit);
    if (32'(lbl_sum) > MAX_CLUSTERS - 1) lbl_c = LBW'(MAX_CLUSTERS - 1);
    else                                 lbl_c = LBW'(lbl_sum);
  end

  // Channel pointer; a sync in the same cycle as an event claims that event for channel 0.
  always_comb begin
    ch_eff = ch_sync ? '0 : ch_q;
    ch_d   = ch_q;
    if (out_valid) ch_d = (ch_eff == CW'(CHANNEL_COUNT - 1)) ? '0 : ch_eff + CW'(1);
    else if (ch_sync) ch_d = '0;
    ev_idx = AW'(32'(ch_eff) * MAX_CLUSTERS + 32'(lbl_c));
  end

  // Counter next-state, read mux and saturation detect; read sees the pre-update value.
  always_comb begin
    rd_val  = '0;
    sat_set = 1'b0;
    for (int i = 0; i < int'(NCNT); i++) begin
      cnt_d[i] = cnt_q[i];
      if (rd_req && rd_addr == AW'(i)) rd_val = cnt_q[i];
      if (rd_req && rd_clear && rd_addr == AW'(i)) begin
        cnt_d[i] = (out_valid && ev_idx == AW'(i)) ? COUNT_WIDTH'(1) : '0;
      end else if (out_valid && ev_idx == AW'(i)) begin
        if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(1);
        if (cnt_q[i] >= CNT_MAX - COUNT_WIDTH'(1)) sat_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(NCNT); i++) cnt_q[i] <= '0;
      ch_q          <= '0;
      label_valid_q <= 1'b0;
      label_q       <= '0;
      label_ch_q    <= '0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      saturated_q   <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NCNT); i++) cnt_q[i] <= cnt_d[i];
      ch_q          <= ch_d;
      label_valid_q <= out_valid;
      if (out_valid) begin
        label_q    <= lbl_c;
        label_ch_q <= ch_eff;
      end
      rd_valid_q <= rd_req;
      if (rd_req) rd_data_q <= rd_val;
      saturated_q <= saturated_q | sat_set;
    end
  end

  assign label_valid = label_valid_q;
  assign label       = label_q;
  assign label_ch    = label_ch_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign saturated   = saturated_q;

endmodule

// File: tb/tb_spike_tally.sv
// Directed bench for spike_tally: a 16-bit counter instance and a 4-bit counter
// instance share one stimulus stream; expected values are hand-derived.
module tb_spike_tally;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  level, path;
  logic        out_valid, ch_sync;
  logic        rd_req, rd_clear;
  logic [4:0]  rd_addr;

  logic        lv_a, lv_b;
  logic [2:0]  lbl_a, lbl_b;
  logic [1:0]  lch_a, lch_b;
  logic        rv_a, rv_b;
  logic [15:0] rd_a;
  logic [3:0]  rd_b;
  logic        sat_a, sat_b;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spike_tally #(.COUNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .level(level), .path(path), .out_valid(out_valid),
    .ch_sync(ch_sync), .label_valid(lv_a), .label(lbl_a), .label_ch(lch_a),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_clear(rd_clear), .rd_valid(rv_a),
    .rd_data(rd_a), .saturated(sat_a)
  );

  spike_tally #(.COUNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .level(level), .path(path), .out_valid(out_valid),
    .ch_sync(ch_sync), .label_valid(lv_b), .label(lbl_b), .label_ch(lch_b),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_clear(rd_clear), .rd_valid(rv_b),
    .rd_data(rd_b), .saturated(sat_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1ns after the edge on return.
  task automatic cyc(input logic ov, input logic [1:0] lvl, input logic [1:0] pth,
                     input logic sy, input logic rq, input logic [4:0] addr, input logic clr);
    out_valid = ov; level = lvl; path = pth; ch_sync = sy;
    rd_req = rq; rd_addr = addr; rd_clear = clr;
    @(posedge clk); #1;
    out_valid = 1'b0; ch_sync = 1'b0; rd_req = 1'b0; rd_clear = 1'b0;
  endtask

  task automatic ev(input logic [1:0] lvl, input logic [1:0] pth, input logic sy);
    cyc(1'b1, lvl, pth, sy, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic rd(input logic [4:0] addr, input logic clr);
    cyc(1'b0, 2'd0, 2'd0, 1'b0, 1'b1, addr, clr);
  endtask

  initial begin
    reset = 1'b0;
    out_valid = 1'b0; ch_sync = 1'b0; rd_req = 1'b0; rd_clear = 1'b0;
    level = '0; path = '0; rd_addr = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_label_valid", 32'(lv_a), 0);
    check("rst_label",       32'(lbl_a), 0);
    check("rst_label_ch",    32'(lch_a), 0);
    check("rst_rd_valid",    32'(rv_a), 0);
    check("rst_rd_data",     32'(rd_a), 0);
    check("rst_saturated",   32'(sat_a), 0);
    reset = 1'b1;

    // Round-robin attribution of four level-0 events
    for (int i = 0; i < 4; i++) begin
      ev(2'd0, 2'b00, 1'b0);
      check($sformatf("rr_lv%0d", i),  32'(lv_a), 1);
      check($sformatf("rr_lbl%0d", i), 32'(lbl_a), 0);
      check($sformatf("rr_ch%0d", i),  32'(lch_a), 32'(i));
    end
    cyc(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    check("idle_lv", 32'(lv_a), 0);
    check("idle_ch_hold", 32'(lch_a), 3);
    for (int a = 0; a < 20; a++) begin
      rd(5'(a), 1'b0);
      check($sformatf("rr_rd%0d", a), 32'(rd_a), (a % 5 == 0) ? 1 : 0);
    end
    check("rd_valid", 32'(rv_a), 1);
    rd(5'd25, 1'b0);
    check("rd_oor", 32'(rd_a), 0);
    rd(5'd5, 1'b0);
    cyc(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    check("rd_valid_drop", 32'(rv_a), 0);
    check("rd_data_hold", 32'(rd_a), 1);

    // Decode sweep on channel 0
    ev(2'd1, 2'b10, 1'b1);
    check("dec_l1p10", 32'(lbl_a), 2);
    check("dec_l1p10_ch", 32'(lch_a), 0);
    ev(2'd2, 2'b00, 1'b1);
    check("dec_l2p00", 32'(lbl_a), 2);
    ev(2'd1, 2'b01, 1'b1);
    check("dec_l1p01", 32'(lbl_a), 1);
    rd(5'd2, 1'b0);
    check("dec_cnt2", 32'(rd_a), 2);
    rd(5'd1, 1'b0);
    check("dec_cnt1", 32'(rd_a), 1);

    // Build counter 7 to 3 (and counter 0 to 5), leaving the pointer on channel 1
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 5'd0, 1'b0);
      ev(2'd0, 2'b00, 1'b0);
      ev(2'd1, 2'b10, 1'b0);
    end
    cyc(1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    ev(2'd0, 2'b00, 1'b0);
    cyc(1'b1, 2'd1, 2'b10, 1'b0, 1'b1, 5'd7, 1'b1);
    check("col_clr_data", 32'(rd_a), 3);
    check("col_clr_lbl", 32'(lbl_a), 2);
    check("col_clr_ch", 32'(lch_a), 1);
    rd(5'd7, 1'b0);
    check("col_clr_after", 32'(rd_a), 1);
    rd(5'd0, 1'b1);
    check("clr_read", 32'(rd_a), 5);
    rd(5'd0, 1'b0);
    check("clr_after", 32'(rd_a), 0);
    cyc(1'b1, 2'd0, 2'b00, 1'b0, 1'b1, 5'd10, 1'b0);
    check("col_inc_data", 32'(rd_a), 1);
    check("col_inc_ch", 32'(lch_a), 2);
    rd(5'd10, 1'b0);
    check("col_inc_after", 32'(rd_a), 2);

    // ch_sync coincident with an event after two prior events
    cyc(1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    ev(2'd0, 2'b00, 1'b0);
    check("sync_pre0", 32'(lch_a), 0);
    ev(2'd0, 2'b00, 1'b0);
    check("sync_pre1", 32'(lch_a), 1);
    ev(2'd0, 2'b00, 1'b1);
    check("sync_ev_ch", 32'(lch_a), 0);
    ev(2'd0, 2'b00, 1'b0);
    check("sync_next_ch", 32'(lch_a), 1);

    // Saturation on the 4-bit instance
    rd(5'd0, 1'b1);
    check("sat_pre_clr", 32'(rd_a), 2);
    check("sat_pre_flag", 32'(sat_b), 0);
    for (int i = 1; i <= 17; i++) begin
      ev(2'd0, 2'b00, 1'b1);
      if (i == 14) check("sat_flag_14", 32'(sat_b), 0);
      if (i == 15) check("sat_flag_15", 32'(sat_b), 1);
    end
    rd(5'd0, 1'b0);
    check("sat_rd4", 32'(rd_b), 15);
    check("sat_rd16", 32'(rd_a), 17);
    check("sat_flag4", 32'(sat_b), 1);
    check("sat_flag16", 32'(sat_a), 0);
    rd(5'd0, 1'b1);
    check("sat_clr_rd", 32'(rd_b), 15);
    rd(5'd0, 1'b0);
    check("sat_clr_after", 32'(rd_b), 0);
    check("sat_sticky", 32'(sat_b), 1);

    // Reset mid-stream with a read and an event pending
    reset = 1'b0;
    cyc(1'b1, 2'd1, 2'b10, 1'b0, 1'b1, 5'd5, 1'b0);
    reset = 1'b1;
    check("mrst_rd_valid", 32'(rv_a), 0);
    check("mrst_rd_data", 32'(rd_a), 0);
    check("mrst_lv", 32'(lv_a), 0);
    check("mrst_sat4", 32'(sat_b), 0);
    for (int a = 0; a < 20; a++) begin
      rd(5'(a), 1'b0);
      check($sformatf("mrst_rd16_%0d", a), 32'(rd_a), 0);
      check($sformatf("mrst_rd4_%0d", a), 32'(rd_b), 0);
    end
    ev(2'd0, 2'b01, 1'b0);
    check("mrst_ev_lv", 32'(lv_a), 1);
    check("mrst_ev_ch", 32'(lch_a), 0);
    check("mrst_ev_lbl", 32'(lbl_a), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
